// File: rtl/shift_reg_universal.sv
// Universal shift register: parallel load, logical/arithmetic shifts, rotates and
// clear, with serial I/O on both ends and a saturating shift counter.
module shift_reg_universal #(
    parameter int WIDTH   = 8,
    parameter bit EDGE_EN = 1'b0,
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_EN,
    input  logic [2:0]       i_MODE,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_SER_L,
    input  logic             i_SER_R,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_SER_L,
    output logic             o_SER_R,
    output logic [CNT_W-1:0] o_CNT,
    output logic             o_DONE
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             qen;

    // In edge mode an operation fires only on the cycle i_EN goes from low to high.
    generate
        if (EDGE_EN) begin : g_edge
            logic en_q;

            always_ff @(posedge i_CLK or negedge i_RST_N) begin
                if (!i_RST_N) begin
                    en_q <= 1'b0;
                end else begin
                    en_q <= i_EN;
                end
            end

            assign qen = i_EN & ~en_q;
        end else begin : g_level
            assign qen = i_EN;
        end
    endgenerate

    function automatic logic [WIDTH-1:0] data_next(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] load,
        input logic             ser_l,
        input logic             ser_r
    );
        logic signed [WIDTH-1:0] cur_s;
        cur_s = cur;
        case (mode)
            MODE_HOLD: data_next = cur;
            MODE_LOAD: data_next = load;
            MODE_SHL:  data_next = {cur[WIDTH-2:0], ser_r};
            MODE_SHR:  data_next = {ser_l, cur[WIDTH-1:1]};
            MODE_ROL:  data_next = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR:  data_next = {cur[0], cur[WIDTH-1:1]};
            MODE_ASR:  data_next = cur_s >>> 1;
            MODE_CLR:  data_next = '0;
            default:   data_next = cur;
        endcase
    endfunction

    // Every shift or rotate counts; the count sticks at WIDTH until a load or clear.
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] cur,
        input logic [2:0]       mode
    );
        case (mode)
            MODE_HOLD:           count_next = cur;
            MODE_LOAD, MODE_CLR: count_next = '0;
            default:             count_next = (cur == CNT_MAX) ? cur : cur + CNT_ONE;
        endcase
    endfunction

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (qen) begin
            data_d = data_next(data_q, i_MODE, i_DATA, i_SER_L, i_SER_R);
            cnt_d  = count_next(cnt_q, i_MODE);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_DATA  = data_q;
    assign o_SER_L = data_q[WIDTH-1];
    assign o_SER_R = data_q[0];
    assign o_CNT   = cnt_q;
    assign o_DONE  = (cnt_q == CNT_MAX);

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal register: the next generation of the team's parallel-in/parallel-out register. It adds parallel load plus logical/arithmetic shift, rotate, and clear modes, with serial I/O on both ends. A saturating shift counter flags when a full word has been shifted. It sits between switch/button input logic and LED or serial output logic, and serves as a general serializer/deserializer stage.

## Interface
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- EDGE_EN, 0, enable qualification:
  - 0: i_EN is level-sensitive (one operation per cycle while high).
  - 1: one operation per rising edge of i_EN.
- CNT_W, $clog2(WIDTH+1), width of the shift counter.

Ports (clock and reset first):
- i_CLK  in  1  sole clock; all state updates on its rising edge.
- i_RST_N  in  1  asynchronous, active-low reset; clears all state immediately.
- i_EN  in  1  operation enable, qualified per EDGE_EN.
- i_MODE  in  3  operation select, sampled only when the qualified enable is true.
- i_DATA  in  WIDTH  parallel load value.
- i_SER_L  in  1  serial bit inserted at the MSB on a logical right shift.
- i_SER_R  in  1  serial bit inserted at the LSB on a left shift.
- o_DATA  out  WIDTH  register contents; reset value 0.
- o_SER_L  out  1  equals o_DATA[WIDTH-1], combinational from the register; reset value 0.
- o_SER_R  out  1  equals o_DATA[0], combinational from the register; reset value 0.
- o_CNT  out  CNT_W  shift/rotate count since the last load or clear; reset value 0.
- o_DONE  out  1  high while o_CNT == WIDTH; reset value 0.

## Operation
- Qualified enable:
  - EDGE_EN=0: qen = i_EN.
  - EDGE_EN=1: qen = i_EN & ~en_q, where en_q is i_EN registered and reset to 0.
  - Consequence for EDGE_EN=1: if i_EN is held high across reset release, exactly one operation fires on the first clock.
- When qen=0: the register, counter and o_DONE all hold.
- i_MODE when qen=1:
  - 000 HOLD: no change; counter unchanged.
  - 001 LOAD: o_DATA <= i_DATA; counter <= 0.
  - 010 SHL: o_DATA <= {o_DATA[WIDTH-2:0], i_SER_R}.
  - 011 SHR: o_DATA <= {i_SER_L, o_DATA[WIDTH-1:1]}.
  - 100 ROL: o_DATA <= {o_DATA[WIDTH-2:0], o_DATA[WIDTH-1]}.
  - 101 ROR: o_DATA <= {o_DATA[0], o_DATA[WIDTH-1:1]}.
  - 110 ASR: o_DATA <= {o_DATA[WIDTH-1], o_DATA[WIDTH-1:1]}.
  - 111 CLR: o_DATA <= 0; counter <= 0.
- Counter rules:
  - Modes 010–110 increment the counter by 1.
  - The counter saturates at WIDTH and never wraps.
  - Shifts continue to operate on o_DATA after the counter saturates.
- o_DONE is derived from the registered counter; it stays high until a LOAD, CLR, or reset.
- Serial inputs are sampled only in their own modes: i_SER_R for SHL, i_SER_L for SHR. ROL, ROR and ASR ignore both.
- No illegal encodings exist; all 8 modes are defined.

## Timing
- Latency: every operation is visible on o_DATA, o_CNT and o_DONE one clock after the qualifying edge. o_SER_L and o_SER_R follow o_DATA in the same cycle.
- Reset:
  - Asserting i_RST_N low forces o_DATA, the counter, o_DONE and en_q to 0 without waiting for a clock, including mid-operation.
  - On release, the first rising edge processes normally.
- The Nth consecutive enabled shift after a LOAD sets o_DONE in the cycle after the Nth edge, where N = WIDTH.
- EDGE_EN=1: an i_EN pulse of any length of at least 1 cycle yields exactly one operation. Back-to-back operations require i_EN to drop low for at least 1 cycle between them.

## Test plan
- Reset mid-op:
  - Stimulus: LOAD 0xA5, then pull i_RST_N low between clock edges.
  - Required: o_DATA=0x00, o_CNT=0 and o_DONE=0 immediately.
  - Required after release: o_DATA stays 0x00 while i_EN=0.
- Shift left:
  - Stimulus: LOAD 0xA5, then SHL with i_SER_R=1.
  - Required: o_DATA=0x4B, o_CNT=1, o_SER_L=0.
- Rotate and arithmetic shift:
  - Stimulus: LOAD 0x81, then ROR.
  - Required: o_DATA=0xC0.
  - Stimulus: LOAD 0x80, then three ASR.
  - Required: o_DATA=0xF0, o_CNT=3.
- Deserialize and saturate:
  - Stimulus: CLR, then 8× SHR with i_SER_L=1.
  - Required: o_DATA=0xFF, o_CNT=8, and o_DONE rises only after the 8th edge.
  - Stimulus: a 9th SHR.
  - Required: o_CNT stays 8.
  - Stimulus: LOAD 0x00.
  - Required: o_CNT=0, o_DONE=0.
- Edge mode:
  - Stimulus: EDGE_EN=1, LOAD 0x01, then i_EN held high for 5 cycles in SHL with i_SER_R=0.
  - Required: o_DATA=0x02, o_CNT=1.
  - Stimulus: i_EN low 1 cycle, then high again.
  - Required: o_DATA=0x04.
- Width generalisation:
  - Stimulus: WIDTH=16, LOAD 0x8001, then ROL.
  - Required: o_DATA=0x0003.
  - Stimulus: 16 consecutive ROL after a LOAD.
  - Required: the loaded value returns and o_DONE=1.
